bht_branch_ctrl: RTL and testbench
==================================

Name: bht_branch_ctrl

Overview:
- Branch-direction and BTB-maintenance stage paired with the 4096-entry BTB in the IF stage.
- Holds a table of 2-bit saturating direction counters and combines the BTB hit/target with the counter to form the IF next-PC.
- Carries each prediction down its own IF->ID->EX shadow pipeline.
- At EX, resolves branches, raises mispredict/redirect, produces the BTB write command (web/waddr/wr_data) and updates the counters and performance counters.

Parameters:
- BHT_ADDR_LEN, 12, counter index width; table depth is 2^BHT_ADDR_LEN entries.
- CNT_INIT, 2'b01, reset value of every direction counter (weakly not-taken).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  32  PC being fetched
- btb_hit  in  1  BTB hit for if_pc
- btb_target  in  32  BTB predicted target for if_pc
- pred_taken  out  1  IF prediction, taken
- pred_pc  out  32  IF next PC
- stall_id  in  1  hold IF/ID shadow register
- flush_id  in  1  clear IF/ID shadow register
- stall_ex  in  1  hold ID/EX shadow register; suppress EX resolution
- flush_ex  in  1  clear ID/EX shadow register
- ex_valid  in  1  EX holds a real instruction
- ex_is_br  in  1  EX instruction is a branch or jump
- ex_pc  in  32  EX instruction PC
- ex_br_taken  in  1  resolved direction
- ex_br_target  in  32  resolved target
- mispredict  out  1  redirect required
- redirect_pc  out  32  correct next PC
- btb_web  out  2  00 none, 01 update target, 10 add entry, 11 invalidate
- btb_waddr  out  32  equals ex_pc
- btb_wdata  out  32  equals ex_br_target
- br_cnt  out  32  resolved branches
- miss_cnt  out  32  mispredictions

Behaviour:
- Index: idx(pc) = pc[BHT_ADDR_LEN+1:2].
- IF prediction is combinational.
  - pred_taken = btb_hit & bht[idx(if_pc)][1].
  - pred_pc = pred_taken ? btb_target : if_pc+4. Addition is 32-bit and wraps.
- Shadow pipeline: {taken, target, hit} moves IF->ID->EX on each posedge.
  - Flush has priority over stall. Flush loads {0, 0, 0}.
  - Stall holds the register.
- Resolution fires when res = ex_valid & !stall_ex. Let {pt, ptgt, ph} be the EX shadow entry.
- Branch case (ex_is_br=1):
  - mispredict = (pt != ex_br_taken) | (ex_br_taken & ptgt != ex_br_target).
  - redirect_pc = ex_br_taken ? ex_br_target : ex_pc+4.
- Non-branch case (ex_is_br=0), covering an aliased BTB hit:
  - mispredict = pt.
  - redirect_pc = ex_pc+4.
- btb_web is combinational and 00 unless res. Priority order:
  - non-branch & ph: 11.
  - taken & !ph: 10.
  - taken & ph & (ptgt != ex_br_target): 01.
  - !taken & ph & counter==00 after update: 11.
  - otherwise: 00.
- Counter update happens at posedge when res & ex_is_br.
  - Taken: saturating increment, 11 stays 11.
  - Not taken: saturating decrement, 00 stays 00.
- Same-index IF read and EX update in the same cycle: IF sees the pre-update value.
- br_cnt increments on res & ex_is_br. miss_cnt increments on res & mispredict. Both wrap at 2^32.
- mispredict, redirect_pc and btb_web are 0 when !res.
- Reset (async assert, any time):
  - all counters load CNT_INIT;
  - shadow registers, br_cnt and miss_cnt load 0;
  - all combinational outputs derive from the reset state: pred_taken=0, pred_pc=if_pc+4, mispredict=0, btb_web=00.
  - Release is synchronous to clk.

Test Plan:
- Reset, if_pc=0x100, btb_hit=1 -> pred_taken=0, pred_pc=0x104, all counters 01, br_cnt=0.
- Branch at 0x200 to 0x400 reaches EX with no BTB hit -> mispredict=1, redirect_pc=0x400, btb_web=10, btb_waddr=0x200, btb_wdata=0x400, counter 01->10. Next fetch of 0x200 with btb_hit=1, btb_target=0x400 -> pred_pc=0x400.
- Three more taken resolutions at 0x200 -> counter saturates at 11; then one not-taken -> mispredict=1, redirect_pc=0x204, counter 10, btb_web=00.
- Counter at 01 with hit, resolve not-taken -> counter 00, btb_web=11, mispredict=0.
- Non-branch in EX with shadow pt=1 -> mispredict=1, redirect_pc=ex_pc+4, btb_web=11, br_cnt unchanged, miss_cnt+1.
- Shadow pipeline and mid-operation reset:
  - Branch in EX with stall_ex=1 for 2 cycles -> no update and counts unchanged until stall drops, then exactly one update.
  - flush_ex together with stall_ex -> EX shadow cleared.
  - rst_n low mid-sequence -> counters back to 01 and counts to 0.

Source files
------------

// File: rtl/bht_branch_ctrl.sv
// Branch direction predictor (2-bit counters) with IF->ID->EX prediction shadow
// pipeline, EX-stage resolution, BTB maintenance commands and performance counters.
module bht_branch_ctrl #(
  parameter int          BHT_ADDR_LEN = 12,
  parameter logic [1:0]  CNT_INIT     = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        stall_id,
  input  logic        flush_id,
  input  logic        stall_ex,
  input  logic        flush_ex,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [1:0]  btb_web,
  output logic [31:0] btb_waddr,
  output logic [31:0] btb_wdata,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int BHT_DEPTH = 1 << BHT_ADDR_LEN;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        hit;
  } shadow_t;

  logic [1:0]              bht [BHT_DEPTH];
  logic [BHT_ADDR_LEN-1:0] if_idx;
  logic [BHT_ADDR_LEN-1:0] ex_idx;
  shadow_t                 if_sh;
  shadow_t                 id_sh;
  shadow_t                 ex_sh;
  logic                    res;
  logic [1:0]              cur_cnt;
  logic [1:0]              nxt_cnt;

  assign if_idx     = if_pc[BHT_ADDR_LEN+1:2];
  assign ex_idx     = ex_pc[BHT_ADDR_LEN+1:2];
  assign pred_taken = btb_hit & bht[if_idx][1];
  assign pred_pc    = pred_taken ? btb_target : if_pc + 32'd4;

  // The raw BTB target travels with the prediction so EX can tell a stale
  // BTB target apart from a pure direction miss.
  assign if_sh = '{taken: pred_taken, target: btb_target, hit: btb_hit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_sh <= '0;
      ex_sh <= '0;
    end else begin
      if (flush_id)
        id_sh <= '0;
      else if (!stall_id)
        id_sh <= if_sh;
      if (flush_ex)
        ex_sh <= '0;
      else if (!stall_ex)
        ex_sh <= id_sh;
    end
  end

  assign res       = ex_valid & ~stall_ex;
  assign cur_cnt   = bht[ex_idx];
  assign btb_waddr = ex_pc;
  assign btb_wdata = ex_br_target;

  always_comb begin
    nxt_cnt     = cur_cnt;
    mispredict  = 1'b0;
    redirect_pc = 32'd0;
    btb_web     = 2'b00;
    if (ex_br_taken)
      nxt_cnt = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'd1;
    else
      nxt_cnt = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'd1;
    if (res) begin
      if (ex_is_br) begin
        mispredict  = (ex_sh.taken != ex_br_taken) |
                      (ex_br_taken & (ex_sh.target != ex_br_target));
        redirect_pc = ex_br_taken ? ex_br_target : ex_pc + 32'd4;
      end else begin
        mispredict  = ex_sh.taken;
        redirect_pc = ex_pc + 32'd4;
      end
      // A BTB hit on a non-branch is an alias and gets evicted; a not-taken
      // branch whose counter bottoms out is evicted to free the entry.
      if (!ex_is_br && ex_sh.hit)
        btb_web = 2'b11;
      else if (ex_is_br && ex_br_taken && !ex_sh.hit)
        btb_web = 2'b10;
      else if (ex_is_br && ex_br_taken && ex_sh.hit && (ex_sh.target != ex_br_target))
        btb_web = 2'b01;
      else if (ex_is_br && !ex_br_taken && ex_sh.hit && (nxt_cnt == 2'b00))
        btb_web = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= CNT_INIT;
    end else if (res && ex_is_br) begin
      bht[ex_idx] <= nxt_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (res && ex_is_br)
        br_cnt <= br_cnt + 32'd1;
      if (res && mispredict)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bht_branch_ctrl.sv
// Directed bench for bht_branch_ctrl: the driver queues hand-computed expected
// values each cycle, and a negedge monitor pops and compares them.
module tb_bht_branch_ctrl;

  localparam int F_PT    = 0;
  localparam int F_PPC   = 1;
  localparam int F_MISP  = 2;
  localparam int F_RPC   = 3;
  localparam int F_WEB   = 4;
  localparam int F_WADDR = 5;
  localparam int F_WDATA = 6;
  localparam int F_BR    = 7;
  localparam int F_MISS  = 8;

  typedef struct {
    string       name;
    int          field;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        stall_id;
  logic        flush_id;
  logic        stall_ex;
  logic        flush_ex;
  logic        ex_valid;
  logic        ex_is_br;
  logic [31:0] ex_pc;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [1:0]  btb_web;
  logic [31:0] btb_waddr;
  logic [31:0] btb_wdata;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  exp_t sb[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  bht_branch_ctrl #(.BHT_ADDR_LEN(12), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc(if_pc), .btb_hit(btb_hit), .btb_target(btb_target),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .stall_id(stall_id), .flush_id(flush_id),
    .stall_ex(stall_ex), .flush_ex(flush_ex),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .btb_web(btb_web), .btb_waddr(btb_waddr), .btb_wdata(btb_wdata),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int field);
    case (field)
      F_PT:    return {31'd0, pred_taken};
      F_PPC:   return pred_pc;
      F_MISP:  return {31'd0, mispredict};
      F_RPC:   return redirect_pc;
      F_WEB:   return {30'd0, btb_web};
      F_WADDR: return btb_waddr;
      F_WDATA: return btb_wdata;
      F_BR:    return br_cnt;
      F_MISS:  return miss_cnt;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: everything queued during a cycle is checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = actual(e.field);
      check_cnt++;
      if (act === e.val)
        pass_cnt++;
      else
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
    end
  end

  task automatic chk(input string name, input int field, input logic [31:0] val);
    exp_t e;
    e.name  = name;
    e.field = field;
    e.val   = val;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if_pc        = 32'h1000;
    btb_hit      = 1'b0;
    btb_target   = 32'h0;
    stall_id     = 1'b0;
    flush_id     = 1'b0;
    stall_ex     = 1'b0;
    flush_ex     = 1'b0;
    ex_valid     = 1'b0;
    ex_is_br     = 1'b0;
    ex_pc        = 32'h0;
    ex_br_taken  = 1'b0;
    ex_br_target = 32'h0;
  endtask

  task automatic if_in(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    if_pc      = pc;
    btb_hit    = hit;
    btb_target = tgt;
  endtask

  task automatic ex_in(input logic v, input logic br, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt);
    ex_valid     = v;
    ex_is_br     = br;
    ex_pc        = pc;
    ex_br_taken  = tk;
    ex_br_target = tgt;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    next_cycle();
    if_in(32'h100, 1'b1, 32'h500);
    chk("rst_pred_taken", F_PT, 32'd0);
    chk("rst_pred_pc", F_PPC, 32'h104);
    chk("rst_br_cnt", F_BR, 32'd0);
    chk("rst_miss_cnt", F_MISS, 32'd0);
    chk("rst_mispredict", F_MISP, 32'd0);
    chk("rst_btb_web", F_WEB, 32'd0);

    // New branch 0x200 -> 0x400, fetched without a BTB hit
    next_cycle(); rst_n = 1'b1;
    if_in(32'h200, 1'b0, 32'h0);
    chk("c1_pred_pc", F_PPC, 32'h204);
    next_cycle();
    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    ex_in(1'b1, 1'b1, 32'h200, 1'b1, 32'h400);
    chk("add_mispredict", F_MISP, 32'd1);
    chk("add_redirect", F_RPC, 32'h400);
    chk("add_web", F_WEB, 32'd2);
    chk("add_waddr", F_WADDR, 32'h200);
    chk("add_wdata", F_WDATA, 32'h400);
    chk("add_br_cnt_before", F_BR, 32'd0);
    chk("same_idx_pred_taken", F_PT, 32'd0);
    chk("same_idx_pred_pc", F_PPC, 32'h204);

    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    chk("hit_pred_taken", F_PT, 32'd1);
    chk("hit_pred_pc", F_PPC, 32'h400);
    chk("c4_br_cnt", F_BR, 32'd1);
    chk("c4_miss_cnt", F_MISS, 32'd1);
    chk("idle_mispredict", F_MISP, 32'd0);
    chk("idle_web", F_WEB, 32'd0);

    // Three taken resolutions drive the counter to saturation
    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    ex_in(1'b1, 1'b1, 32'h200, 1'b1, 32'h400);
    chk("t1_mispredict", F_MISP, 32'd1);
    chk("t1_redirect", F_RPC, 32'h400);
    chk("t1_web", F_WEB, 32'd0);
    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    ex_in(1'b1, 1'b1, 32'h200, 1'b1, 32'h400);
    chk("t2_mispredict", F_MISP, 32'd0);
    chk("t2_web", F_WEB, 32'd0);
    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    ex_in(1'b1, 1'b1, 32'h200, 1'b1, 32'h400);
    chk("t3_mispredict", F_MISP, 32'd0);
    chk("t3_br_cnt", F_BR, 32'd3);
    chk("t3_miss_cnt", F_MISS, 32'd2);

    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    ex_in(1'b1, 1'b1, 32'h200, 1'b0, 32'h400);
    chk("nt_pred_taken_sat", F_PT, 32'd1);
    chk("nt_mispredict", F_MISP, 32'd1);
    chk("nt_redirect", F_RPC, 32'h204);
    chk("nt_web", F_WEB, 32'd0);
    chk("nt_br_cnt_before", F_BR, 32'd4);
    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    chk("nt_pred_after", F_PT, 32'd1);
    chk("nt_br_cnt", F_BR, 32'd5);
    chk("nt_miss_cnt", F_MISS, 32'd3);

    // Weakly not-taken hit resolving not-taken evicts the entry
    next_cycle();
    if_in(32'h300, 1'b1, 32'h800);
    chk("c10_pred_taken", F_PT, 32'd0);
    chk("c10_pred_pc", F_PPC, 32'h304);
    next_cycle();
    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    ex_in(1'b1, 1'b1, 32'h300, 1'b0, 32'h800);
    chk("evict_mispredict", F_MISP, 32'd0);
    chk("evict_web", F_WEB, 32'd3);
    chk("evict_redirect", F_RPC, 32'h304);
    chk("evict_waddr", F_WADDR, 32'h300);
    next_cycle();
    chk("c13_br_cnt", F_BR, 32'd6);
    chk("c13_miss_cnt", F_MISS, 32'd3);

    // Aliased BTB hit on a non-branch
    next_cycle();
    ex_in(1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
    chk("alias_mispredict", F_MISP, 32'd1);
    chk("alias_redirect", F_RPC, 32'h204);
    chk("alias_web", F_WEB, 32'd3);
    next_cycle();
    if_in(32'h300, 1'b1, 32'h800);
    chk("alias_br_cnt", F_BR, 32'd6);
    chk("alias_miss_cnt", F_MISS, 32'd4);
    chk("c15_pred_taken", F_PT, 32'd0);

    // EX stall holds resolution for two cycles
    next_cycle();
    next_cycle();
    ex_in(1'b1, 1'b1, 32'h300, 1'b1, 32'h800);
    stall_ex = 1'b1;
    chk("stall1_mispredict", F_MISP, 32'd0);
    chk("stall1_web", F_WEB, 32'd0);
    chk("stall1_redirect", F_RPC, 32'd0);
    next_cycle();
    ex_in(1'b1, 1'b1, 32'h300, 1'b1, 32'h800);
    stall_ex = 1'b1;
    chk("stall2_mispredict", F_MISP, 32'd0);
    chk("stall2_br_cnt", F_BR, 32'd6);
    chk("stall2_miss_cnt", F_MISS, 32'd4);
    next_cycle();
    ex_in(1'b1, 1'b1, 32'h300, 1'b1, 32'h800);
    chk("unstall_mispredict", F_MISP, 32'd1);
    chk("unstall_redirect", F_RPC, 32'h800);
    chk("unstall_web", F_WEB, 32'd0);
    next_cycle();
    if_in(32'h300, 1'b1, 32'h800);
    chk("unstall_br_cnt", F_BR, 32'd7);
    chk("unstall_miss_cnt", F_MISS, 32'd5);
    chk("unstall_one_update", F_PT, 32'd0);

    // Flush wins over stall in the ID/EX shadow register
    next_cycle();
    if_in(32'h200, 1'b1, 32'h400);
    next_cycle();
    next_cycle();
    ex_in(1'b1, 1'b1, 32'h200, 1'b1, 32'h400);
    stall_ex = 1'b1;
    flush_ex = 1'b1;
    chk("flush_mispredict", F_MISP, 32'd0);
    next_cycle();
    ex_in(1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
    chk("flushed_mispredict", F_MISP, 32'd0);
    chk("flushed_web", F_WEB, 32'd0);
    chk("flushed_redirect", F_RPC, 32'h204);
    next_cycle();
    chk("flushed_miss_cnt", F_MISS, 32'd5);
    chk("flushed_br_cnt", F_BR, 32'd7);

    // Asynchronous reset mid-sequence
    next_cycle();
    rst_n = 1'b0;
    if_in(32'h200, 1'b1, 32'h400);
    chk("mid_rst_pred_taken", F_PT, 32'd0);
    chk("mid_rst_pred_pc", F_PPC, 32'h204);
    chk("mid_rst_br_cnt", F_BR, 32'd0);
    chk("mid_rst_miss_cnt", F_MISS, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    if_in(32'h200, 1'b1, 32'h400);
    chk("post_rst_pred_taken", F_PT, 32'd0);
    chk("post_rst_br_cnt", F_BR, 32'd0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      check_cnt++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
